// File: rtl/tsu_ts_queue.sv
// ----------------------------------------------------------------------------
// tsu_ts_queue
// Timestamp record queue between the time-stamping unit and the register bank.
// Captured PTP timestamp records are pushed in; the oldest record is presented
// on head_o for the tx/rx timestamp read words and discarded by a pop pulse
// from bus decode. On overflow the new record is dropped and counted.
//
// Ports
//   bus2ip_clk    in   clock, rising edge
//   bus2ip_rst_n  in   asynchronous active-low reset
//   push_i        in   pulse, rec_i valid
//   rec_i         in   224-bit timestamp record
//   pop_i         in   pulse, discard head record
//   clr_i         in   pulse, flush queue and clear status
//   head_o        out  oldest record (zero when empty)
//   head_vld_o    out  queue non-empty
//   level_o       out  records held
//   full_o        out  level_o == DEPTH
//   ovf_o         out  sticky, a record was dropped
//   drop_cnt_o    out  dropped-record count, saturating at 255
// ----------------------------------------------------------------------------
module tsu_ts_queue #(
    parameter int unsigned DEPTH = 4,
    parameter int unsigned AW    = 2
) (
    input  logic              bus2ip_clk,
    input  logic              bus2ip_rst_n,
    input  logic              push_i,
    input  logic [223:0]      rec_i,
    input  logic              pop_i,
    input  logic              clr_i,
    output logic [223:0]      head_o,
    output logic              head_vld_o,
    output logic [AW:0]       level_o,
    output logic              full_o,
    output logic              ovf_o,
    output logic [7:0]        drop_cnt_o
);

    localparam int unsigned RW = 224;
    localparam int unsigned LW = AW + 1;
    localparam int unsigned CW = 8;

    logic [RW-1:0] mem_q [DEPTH];

    logic [AW-1:0] wr_ptr_q, wr_ptr_d;
    logic [AW-1:0] rd_ptr_q, rd_ptr_d;
    logic [LW-1:0] level_q,  level_d;
    logic          ovf_q,    ovf_d;
    logic [CW-1:0] drop_q,   drop_d;

    logic empty;
    logic full;
    logic push_acc;
    logic pop_acc;
    logic drop;

    assign empty = (level_q == LW'(0));
    assign full  = (level_q == LW'(DEPTH));

    // A pop is always accepted when full, so push+pop on a full queue fits.
    // An empty queue ignores pop, so push+pop on empty is a plain push.
    assign pop_acc  = pop_i && !empty && !clr_i;
    assign push_acc = push_i && (!full || pop_i) && !clr_i;
    assign drop     = push_i && full && !pop_i && !clr_i;

    // Next-state for pointers, level and overflow status
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        level_d  = level_q;
        ovf_d    = ovf_q;
        drop_d   = drop_q;
        if (clr_i) begin
            wr_ptr_d = AW'(0);
            rd_ptr_d = AW'(0);
            level_d  = LW'(0);
            ovf_d    = 1'b0;
            drop_d   = CW'(0);
        end else begin
            if (push_acc) begin
                wr_ptr_d = wr_ptr_q + AW'(1);
            end
            if (pop_acc) begin
                rd_ptr_d = rd_ptr_q + AW'(1);
            end
            if (push_acc && !pop_acc) begin
                level_d = level_q + LW'(1);
            end else if (pop_acc && !push_acc) begin
                level_d = level_q - LW'(1);
            end
            if (drop) begin
                ovf_d = 1'b1;
                if (drop_q != {CW{1'b1}}) begin
                    drop_d = drop_q + CW'(1);
                end
            end
        end
    end

    // Control state register
    always_ff @(posedge bus2ip_clk or negedge bus2ip_rst_n) begin
        if (!bus2ip_rst_n) begin
            wr_ptr_q <= AW'(0);
            rd_ptr_q <= AW'(0);
            level_q  <= LW'(0);
            ovf_q    <= 1'b0;
            drop_q   <= CW'(0);
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            level_q  <= level_d;
            ovf_q    <= ovf_d;
            drop_q   <= drop_d;
        end
    end

    // Record storage; contents are qualified by level, so no reset needed
    always_ff @(posedge bus2ip_clk) begin
        if (push_acc) begin
            mem_q[wr_ptr_q] <= rec_i;
        end
    end

    // Outputs decoded from registered state only
    always_comb begin
        head_o     = '0;
        head_vld_o = !empty;
        if (!empty) begin
            head_o = mem_q[rd_ptr_q];
        end
    end

    assign level_o    = level_q;
    assign full_o     = full;
    assign ovf_o      = ovf_q;
    assign drop_cnt_o = drop_q;

endmodule

// File: tb/tb_tsu_ts_queue.sv
// ----------------------------------------------------------------------------
// tb_tsu_ts_queue
// Self-checking bench: directed scenarios plus random push/pop/clr traffic,
// compared against a queue-based reference model of the timestamp queue.
// ----------------------------------------------------------------------------
module tb_tsu_ts_queue;

    localparam int unsigned DEPTH = 4;
    localparam int unsigned AW    = 2;

    logic         clk;
    logic         rst_n;
    logic         push;
    logic [223:0] rec;
    logic         pop;
    logic         clr;
    logic [223:0] head;
    logic         head_vld;
    logic [AW:0]  level;
    logic         full;
    logic         ovf;
    logic [7:0]   drop_cnt;

    tsu_ts_queue #(.DEPTH(DEPTH), .AW(AW)) dut (
        .bus2ip_clk   (clk),
        .bus2ip_rst_n (rst_n),
        .push_i       (push),
        .rec_i        (rec),
        .pop_i        (pop),
        .clr_i        (clr),
        .head_o       (head),
        .head_vld_o   (head_vld),
        .level_o      (level),
        .full_o       (full),
        .ovf_o        (ovf),
        .drop_cnt_o   (drop_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference model
    logic [223:0] mq[$];
    logic         m_ovf;
    int           m_drops;

    int n_chk;
    int n_pass;

    task automatic check(input string tag, input logic [223:0] obs, input logic [223:0] exp);
        n_chk++;
        if (obs === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic logic [223:0] mkrec(input logic [15:0] seq);
        logic [223:0] r;
        for (int i = 0; i < 7; i++) begin
            r[i*32 +: 32] = $urandom;
        end
        r[31:16] = seq;
        return r;
    endfunction

    task automatic model_reset();
        mq.delete();
        m_ovf   = 1'b0;
        m_drops = 0;
    endtask

    task automatic model_step(input logic p, input logic q, input logic c, input logic [223:0] r);
        bit pop_ok;
        bit push_ok;
        if (c) begin
            model_reset();
        end else begin
            pop_ok  = q && (mq.size() > 0);
            push_ok = p && ((mq.size() < DEPTH) || q);
            if (pop_ok) void'(mq.pop_front());
            if (push_ok) mq.push_back(r);
            if (p && !push_ok) begin
                m_ovf = 1'b1;
                if (m_drops < 255) m_drops++;
            end
        end
    endtask

    task automatic compare_all(input string tag);
        logic [223:0] exp_head;
        exp_head = (mq.size() > 0) ? mq[0] : '0;
        check({tag, ".head"},     head,            exp_head);
        check({tag, ".head_vld"}, 224'(head_vld),  224'(mq.size() > 0));
        check({tag, ".level"},    224'(level),     224'(mq.size()));
        check({tag, ".full"},     224'(full),      224'(mq.size() == DEPTH));
        check({tag, ".ovf"},      224'(ovf),       224'(m_ovf));
        check({tag, ".drop_cnt"}, 224'(drop_cnt),  224'(m_drops));
    endtask

    // One clock: drive inputs, let the edge happen, update model, compare
    task automatic step(input logic p, input logic q, input logic c, input logic [223:0] r, input string tag);
        push = p; pop = q; clr = c; rec = r;
        @(posedge clk);
        model_step(p, q, c, r);
        #1;
        push = 1'b0; pop = 1'b0; clr = 1'b0;
        compare_all(tag);
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        #1;
        model_reset();
        compare_all("rst_async");
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        compare_all("rst_rel");
    endtask

    initial begin
        n_chk = 0; n_pass = 0;
        push = 1'b0; pop = 1'b0; clr = 1'b0; rec = '0;
        rst_n = 1'b1;
        model_reset();
        @(posedge clk);
        #1;
        do_reset();

        // Single push, visible next cycle
        step(1, 0, 0, mkrec(16'h0001), "push_a");
        check("a_seq",   224'(head[31:16]), 224'(16'h0001));
        check("a_level", 224'(level),       224'(1));
        step(0, 1, 0, '0, "pop_a");

        // Fill, overflow, drain in order
        for (int i = 1; i <= 4; i++) step(1, 0, 0, mkrec(16'(i)), "fill");
        step(1, 0, 0, mkrec(16'd5), "ovf5");
        check("ovf5_full", 224'(full),     224'(1));
        check("ovf5_ovf",  224'(ovf),      224'(1));
        check("ovf5_cnt",  224'(drop_cnt), 224'(1));
        for (int i = 1; i <= 4; i++) begin
            check("drain_seq", 224'(head[31:16]), 224'(i));
            step(0, 1, 0, '0, "drain");
        end
        check("drain_head0", head, '0);

        // Full queue, push+pop together
        step(0, 0, 1, '0, "clr1");
        for (int i = 1; i <= 4; i++) step(1, 0, 0, mkrec(16'(i)), "fill2");
        step(1, 1, 0, mkrec(16'd9), "pushpop_full");
        check("pp_level", 224'(level), 224'(4));
        for (int i = 0; i < 4; i++) begin
            check("pp_seq", 224'(head[31:16]), 224'((i < 3) ? (i + 2) : 9));
            step(0, 1, 0, '0, "pp_drain");
        end

        // Saturating drop counter, then clear
        for (int i = 1; i <= 4; i++) step(1, 0, 0, mkrec(16'(i)), "fill3");
        for (int i = 0; i < 300; i++) step(1, 0, 0, mkrec(16'(100 + i)), "sat");
        check("sat_cnt", 224'(drop_cnt), 224'(255));
        step(0, 0, 1, '0, "clr_sat");
        check("clr_level", 224'(level),    224'(0));
        check("clr_cnt",   224'(drop_cnt), 224'(0));

        // Empty-queue corner cases
        step(0, 1, 0, '0, "pop_empty");
        step(1, 1, 0, mkrec(16'h00aa), "pushpop_empty");
        check("ppe_level", 224'(level), 224'(1));
        step(1, 0, 1, mkrec(16'h00bb), "clr_push");
        check("cp_level", 224'(level), 224'(0));

        // Push/pop pairs across wrap
        for (int i = 0; i < 10; i++) begin
            step(1, 0, 0, mkrec(16'(200 + i)), "wrap_push");
            check("wrap_seq", 224'(head[31:16]), 224'(200 + i));
            step(0, 1, 0, '0, "wrap_pop");
        end

        // Random traffic with occasional mid-stream reset
        for (int i = 0; i < 600; i++) begin
            if ($urandom_range(0, 199) == 0) begin
                do_reset();
            end else begin
                step(1'($urandom_range(0, 99) < 55), 1'($urandom_range(0, 99) < 45),
                     1'($urandom_range(0, 99) < 2), mkrec(16'($urandom)), "rand");
            end
        end

        // Reset with records queued
        for (int i = 0; i < 3; i++) step(1, 0, 0, mkrec(16'(300 + i)), "pre_rst");
        do_reset();
        check("rst_level", 224'(level), 224'(0));

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule

// File: doc/tsu_ts_queue.md
TSU_TS_QUEUE -- requirements
Module: tsu_ts_queue

Interface
REQ-001 SHALL have parameter: DEPTH, 4, number of timestamp records held (power of two, 2..16).
REQ-002 SHALL have parameter: AW, 2, pointer width, log2(DEPTH).
REQ-003 SHALL have port: bus2ip_clk  input  1  clock; all logic on its rising edge.
REQ-004 SHALL have port: bus2ip_rst_n  input  1  reset, asynchronous, active-low.
REQ-005 SHALL have port: push_i  input  1  one-cycle pulse, a timestamp record is valid on rec_i; already synchronous to bus2ip_clk.
REQ-006 SHALL have port: rec_i  input  224  record: [223:144] timestamp, [143:128] frac_ns, [127:48] sourcePortIdentity, [47:32] flagField, [31:16] seqId, [15:12] majorSdoId, [11:8] messageType, [7:4] minorVersionPTP, [3:0] versionPTP.
REQ-007 SHALL have port: pop_i  input  1  one-cycle pulse from bus decode, discards the head record.
REQ-008 SHALL have port: clr_i  input  1  one-cycle pulse, flushes the queue and clears status.
REQ-009 SHALL have port: head_o  output  224  oldest record, same layout as rec_i, feeding the register-bank tx/rx timestamp read words.
REQ-010 SHALL have port: head_vld_o  output  1  queue non-empty.
REQ-011 SHALL have port: level_o  output  AW+1  records currently held.
REQ-012 SHALL have port: full_o  output  1  level_o == DEPTH.
REQ-013 SHALL have port: ovf_o  output  1  sticky, at least one record dropped.
REQ-014 SHALL have port: drop_cnt_o  output  8  dropped-record count, saturating.

Function
REQ-015 SHALL store records in a DEPTH-entry register array with AW-bit write and read pointers, both wrapping from DEPTH-1 to 0.
REQ-016 SHALL, on push_i with queue not full (or full with simultaneous pop_i), write rec_i at wr_ptr and increment wr_ptr.
REQ-017 SHALL, on pop_i with queue non-empty, increment rd_ptr; pop_i on an empty queue SHALL be ignored, with no state change.
REQ-018 SHALL update level_o as +1 (push only), -1 (pop only), unchanged (push and pop both accepted, or neither).
REQ-019 SHALL, on push_i when full without pop_i, drop rec_i, leave the array and pointers unchanged, set ovf_o, and increment drop_cnt_o, saturating at 255.
REQ-020 SHALL, on simultaneous push_i and pop_i while empty, accept the push and ignore the pop (level becomes 1).
REQ-021 SHALL drive head_o = array[rd_ptr] when head_vld_o=1, otherwise all-zero; head_o and head_vld_o SHALL be decoded from registered state only, so no combinational path exists from push_i/pop_i/clr_i/rec_i to any output.
REQ-022 SHALL make a record pushed at edge N visible on head_o/head_vld_o in the cycle after edge N (latency 1) when the queue was empty.
REQ-023 SHALL, on clr_i, zero both pointers, level_o, ovf_o and drop_cnt_o; clr_i SHALL take priority over push_i and pop_i in the same cycle, and both SHALL be discarded.
REQ-024 SHALL preserve FIFO order across pointer wrap-around.

Reset
REQ-025 SHALL, while bus2ip_rst_n=0, hold both pointers, level_o, ovf_o and drop_cnt_o at 0, hold head_vld_o and full_o at 0, and drive head_o all-zero; array contents need not be reset.
REQ-026 SHALL abandon any queued records on reset assertion mid-operation and restart empty after release.

Verification
REQ-027 SHALL pass: reset, then push rec A (seqId 16'h0001) -> next cycle head_vld_o=1, head_o[31:16]=16'h0001, level_o=1.
REQ-028 SHALL pass: push seqIds 1..4 with DEPTH=4, then push 5 -> full_o=1, ovf_o=1, drop_cnt_o=1; then 4 pops yield seqIds 1,2,3,4 and head_o=0.
REQ-029 SHALL pass: full queue, push seqId 9 and pop in the same cycle -> level_o stays 4, and the record 9 emerges after the three older records.
REQ-030 SHALL pass: 300 pushes into a full queue -> drop_cnt_o=255 (saturated); then clr_i -> level_o=0, ovf_o=0, drop_cnt_o=0.
REQ-031 SHALL pass: pop on empty, and push+pop on empty -> level stays 0, then becomes 1 respectively; clr_i+push in the same cycle -> level_o=0.
REQ-032 SHALL pass: 10 push/pop pairs across pointer wrap -> order preserved; assert bus2ip_rst_n mid-stream -> all outputs 0 immediately.
